// File: rtl/beat_rate_meter.sv
// rtl/beat_rate_meter.sv - inter-beat interval averaging and BPM conversion
//
// Measures the clk-cycle interval between rising edges of the peak finder's
// peak-found level, averages the last AVG_DEPTH intervals and converts the
// average to beats per minute with a serial restoring divider.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   peak_in    in   1  peak-found level; only its rising edge counts as a beat
//   bpm        out  8  latest heart rate in BPM, saturated to 255
//   bpm_valid  out  1  one-cycle strobe when bpm updates
//   no_signal  out  1  high until the first bpm_valid and after any timeout

module beat_rate_meter #(
    parameter int unsigned CLK_HZ         = 40_000_000,
    parameter int unsigned MIN_IBI_CYCLES = 10_000_000,
    parameter int unsigned MAX_IBI_CYCLES = 80_000_000,
    parameter int unsigned AVG_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       peak_in,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       no_signal
);

    localparam int CW  = $clog2(MAX_IBI_CYCLES + 1);
    localparam int LW  = $clog2(AVG_DEPTH);
    localparam int SW  = CW + LW;
    localparam int AW  = (AVG_DEPTH > 1) ? LW : 1;
    localparam int FW  = $clog2(AVG_DEPTH + 1);

    // NUM / average_ibi_sum == 60 * CLK_HZ / mean_ibi, i.e. beats per minute.
    localparam logic [63:0] NUM = 64'(60) * 64'(CLK_HZ) * 64'(AVG_DEPTH);
    localparam int DW  = $clog2(NUM + 1);
    localparam int DCW = $clog2(DW + 1);

    localparam logic [CW-1:0]  MAX_C    = CW'(MAX_IBI_CYCLES);
    localparam logic [CW-1:0]  MIN_C    = CW'(MIN_IBI_CYCLES);
    localparam logic [FW-1:0]  FULL     = FW'(AVG_DEPTH);
    localparam logic [AW-1:0]  PTR_LAST = AW'(AVG_DEPTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DW - 1);
    localparam logic [DW-1:0]  NUM_D    = NUM[DW-1:0];

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    state_t state, state_nxt;

    logic           peak_d;
    logic [CW-1:0]  ibi_cnt;
    logic [CW-1:0]  hist [AVG_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [FW-1:0]  fill;
    logic [SW-1:0]  sum;

    logic [DW-1:0]  rem;
    logic [DW-1:0]  num_sh;
    logic [DW-1:0]  quot;
    logic [DCW-1:0] div_cnt;

    logic           beat;
    logic           timeout;
    logic           accept;
    logic           div_last;
    logic [FW-1:0]  fill_nxt;
    logic [AW-1:0]  ptr_nxt;
    logic [CW-1:0]  oldest;
    logic [SW-1:0]  sum_nxt;
    logic [DW:0]    trial;
    logic           ge;
    logic [DW-1:0]  rem_nxt;
    logic [DW-1:0]  quot_nxt;
    logic [7:0]     bpm_sat;

    assign beat = peak_in & ~peak_d;

    // Control decode and divider step datapath.
    always_comb begin
        timeout  = (state != IDLE) && (ibi_cnt == MAX_C);
        // DIVIDE never accepts a beat: the refractory period outlasts the divide.
        accept   = (state == MEASURE) && beat && !timeout && (ibi_cnt >= MIN_C);
        div_last = (state == DIVIDE) && (div_cnt == DIV_LAST);
        fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
        ptr_nxt  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        // Until the ring is full the slot being overwritten holds no real interval.
        oldest   = (fill == FULL) ? hist[wr_ptr] : '0;
        sum_nxt  = sum + SW'(ibi_cnt) - SW'(oldest);

        trial    = {rem, num_sh[DW-1]};
        ge       = trial >= (DW + 1)'(sum);
        // The true difference is below sum, so the low DW bits are exact.
        rem_nxt  = ge ? (trial[DW-1:0] - DW'(sum)) : trial[DW-1:0];
        quot_nxt = {quot[DW-2:0], ge};
        bpm_sat  = (|quot_nxt[DW-1:8]) ? 8'd255 : quot_nxt[7:0];
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (beat) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_nxt = beat ? MEASURE : IDLE;
                end else if (accept && (fill_nxt == FULL)) begin
                    state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                if (timeout) begin
                    state_nxt = beat ? MEASURE : IDLE;
                end else if (div_last) begin
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_d    <= 1'b0;
            ibi_cnt   <= '0;
            for (int i = 0; i < int'(AVG_DEPTH); i++) begin
                hist[i] <= '0;
            end
            wr_ptr    <= '0;
            fill      <= '0;
            sum       <= '0;
            rem       <= '0;
            num_sh    <= '0;
            quot      <= '0;
            div_cnt   <= '0;
            bpm       <= 8'd0;
            bpm_valid <= 1'b0;
            no_signal <= 1'b1;
        end else begin
            peak_d    <= peak_in;
            bpm_valid <= 1'b0;

            if (state == IDLE) begin
                if (beat) begin
                    ibi_cnt <= '0;
                end
            end else if (timeout) begin
                // Signal lost: forget the history; any divide in flight is dropped
                // because the state leaves DIVIDE without reaching div_last.
                for (int i = 0; i < int'(AVG_DEPTH); i++) begin
                    hist[i] <= '0;
                end
                wr_ptr    <= '0;
                fill      <= '0;
                sum       <= '0;
                no_signal <= 1'b1;
                ibi_cnt   <= '0;
            end else begin
                if (accept) begin
                    hist[wr_ptr] <= ibi_cnt;
                    wr_ptr       <= ptr_nxt;
                    sum          <= sum_nxt;
                    fill         <= fill_nxt;
                    ibi_cnt      <= '0;
                    if (fill_nxt == FULL) begin
                        rem     <= '0;
                        num_sh  <= NUM_D;
                        quot    <= '0;
                        div_cnt <= '0;
                    end
                end else if (ibi_cnt != MAX_C) begin
                    ibi_cnt <= ibi_cnt + 1'b1;
                end

                if (state == DIVIDE) begin
                    rem     <= rem_nxt;
                    num_sh  <= {num_sh[DW-2:0], 1'b0};
                    quot    <= quot_nxt;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_last) begin
                        bpm       <= bpm_sat;
                        bpm_valid <= 1'b1;
                        no_signal <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_beat_rate_meter.sv
// tb/tb_beat_rate_meter.sv - scoreboard bench for beat_rate_meter

module tb_beat_rate_meter;

    localparam int CLK_HZ     = 1000;
    localparam int MIN_IBI    = 250;
    localparam int MAX_IBI    = 2000;
    localparam int AVG        = 4;
    localparam int NUM        = 60 * CLK_HZ * AVG;
    localparam int DIV_CYCLES = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       peak_in = 1'b0;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       no_signal;

    beat_rate_meter #(
        .CLK_HZ        (CLK_HZ),
        .MIN_IBI_CYCLES(MIN_IBI),
        .MAX_IBI_CYCLES(MAX_IBI),
        .AVG_DEPTH     (AVG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .peak_in  (peak_in),
        .bpm      (bpm),
        .bpm_valid(bpm_valid),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int bpm;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    bit   m_idle = 1'b1;
    int   last_c = 0;

    function automatic int sat(input int q);
        return (q > 255) ? 255 : q;
    endfunction

    // Drive one rising edge of peak_in (from a negedge) and update the model.
    task automatic beat(input int width);
        int c;
        int ibi;
        int s;
        peak_in = 1'b1;
        c   = cyc;
        ibi = c - last_c - 1;
        if (m_idle || ibi >= MAX_IBI) begin
            m_idle = 1'b0;
            hist.delete();
            last_c = c;
        end else if (ibi >= MIN_IBI) begin
            hist.push_back(ibi);
            if (hist.size() > AVG) void'(hist.pop_front());
            last_c = c;
            if (hist.size() == AVG) begin
                s = 0;
                foreach (hist[i]) s += hist[i];
                exp_q.push_back('{sat(NUM / s), c + DIV_CYCLES + 1});
            end
        end
        repeat (width) @(negedge clk);
        peak_in = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input int width, input int spacing);
        beat(width);
        gap(spacing - width);
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        hist.delete();
        exp_q.delete();
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (bpm_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bpm", int'(bpm), e.bpm);
                check("strobe_cycle", cyc, e.cyc);
                check("no_signal_at_strobe", int'(no_signal), 0);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            check("missed_strobe", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #(2_000_000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset state and idle quiet period.
        gap(3);
        check("reset_bpm", int'(bpm), 0);
        check("reset_bpm_valid", int'(bpm_valid), 0);
        check("reset_no_signal", int'(no_signal), 1);
        reset = 1'b0;
        gap(5000);
        check("idle_no_signal", int'(no_signal), 1);
        check("idle_bpm", int'(bpm), 0);

        // 1000-cycle train: strobe lands exactly DIV_CYCLES+1 after the 5th edge.
        repeat (4) step(5, 1000);
        c = cyc;
        beat(5);
        gap(DIV_CYCLES - 5);
        check("pre_strobe_cycle", cyc, c + DIV_CYCLES);
        check("pre_strobe_valid", int'(bpm_valid), 0);
        check("pre_strobe_no_signal", int'(no_signal), 1);
        gap(1000 - DIV_CYCLES);
        step(5, 1000);
        step(5, 500);

        // 500-cycle spacing: 68, 80, 96, 120.
        step(5, 500);
        step(5, 500);
        step(5, 500);
        step(5, 1000);
        check("bpm_after_fast", int'(bpm), 120);

        // Back to steady 60.
        repeat (4) step(5, 1000);
        check("bpm_steady", int'(bpm), 60);

        // Spurious edge inside refractory, then a long held-high peak.
        beat(5);
        gap(95);
        beat(10);
        gap(890);
        beat(300);
        gap(700);
        c = cyc;
        beat(5);

        // Timeout: no_signal rises when ibi_cnt reaches MAX, bpm holds.
        while (cyc < c + MAX_IBI + 1) @(negedge clk);
        check("timeout_before", int'(no_signal), 0);
        @(negedge clk);
        check("timeout_no_signal", int'(no_signal), 1);
        check("timeout_bpm_hold", int'(bpm), 60);
        gap(400);
        repeat (4) step(5, 1000);
        check("after_timeout_no_signal", int'(no_signal), 1);
        step(5, 1000);
        check("recovered_no_signal", int'(no_signal), 0);

        // Reset during DIVIDE aborts the strobe.
        beat(5);
        gap(1);
        reset = 1'b1;
        model_reset();
        gap(2);
        check("midiv_bpm", int'(bpm), 0);
        check("midiv_valid", int'(bpm_valid), 0);
        check("midiv_no_signal", int'(no_signal), 1);
        reset = 1'b0;
        gap(100);
        repeat (5) step(5, 1000);
        check("final_bpm", int'(bpm), 60);
        check("final_no_signal", int'(no_signal), 0);
        gap(100);
        check("pending_expected", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
